// File: rtl/audio_request_arbiter_pkg.sv
// Shared types and default values for the audio request arbiter.
package audio_request_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_SEL_W      = 3;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  localparam int unsigned DEF_MAX_PLAY   = 50_000_000;

endpackage

// File: rtl/audio_request_arbiter_if.sv
// Request/Audio-side signal bundle for the arbiter; master = requesters + Audio, slave = arbiter.
interface audio_request_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEL_W   = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SEL_W-1:0] req_sel;
  logic                     mute;
  logic                     seq_end;
  logic                     audio_enable;
  logic [SEL_W-1:0]         audio_select;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       aborted;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output req, req_sel, mute, seq_end,
    input  audio_enable, audio_select, grant, done, aborted, busy, timeout_err
  );

  modport slave (
    input  req, req_sel, mute, seq_end,
    output audio_enable, audio_select, grant, done, aborted, busy, timeout_err
  );
endinterface

// File: rtl/audio_request_arbiter_prio_encoder.sv
// Lowest-set-bit priority encoder with an "any bit set below index k" flag.
module audio_prio_encoder #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   k,
  output logic               valid,
  output logic [IDX_W-1:0]   index,
  output logic               below
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    below = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (mask[i] && !valid) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
      if (mask[i] && (IDX_W'(i) < k)) begin
        below = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_request_arbiter.sv
// Shares one Audio PWM sequencer among prioritised requesters with preemption, mute and watchdog.
module audio_request_arbiter
  import audio_request_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned MAX_PLAY   = DEF_MAX_PLAY
) (
  input logic                  clk,
  input logic                  rst,
  audio_request_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(MAX_PLAY) + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_PLAY - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d, clr;
  logic [SEL_W-1:0]   sel_q [NUM_REQ];
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] aborted_q, aborted_d;
  logic               tmo_q, tmo_d;

  logic               enc_valid;
  logic [IDX_W-1:0]   enc_index;
  logic               enc_below;

  // One encoder serves both jobs: winner selection in IDLE, preemption check against cur in PLAY.
  audio_prio_encoder #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .mask  (pending_q),
    .k     (cur_q),
    .valid (enc_valid),
    .index (enc_index),
    .below (enc_below)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    select_d  = select_q;
    grant_d   = '0;
    done_d    = '0;
    aborted_d = '0;
    tmo_d     = tmo_q;
    clr       = '0;

    case (state_q)
      ST_IDLE: begin
        if (enc_valid && !bus.mute) begin
          state_d             = ST_PLAY;
          select_d            = sel_q[enc_index];
          grant_d[enc_index]  = 1'b1;
          clr[enc_index]      = 1'b1;
          cur_d               = enc_index;
          wd_d                = '0;
        end
      end
      ST_PLAY: begin
        if (bus.mute) begin
          aborted_d[cur_q] = 1'b1;
          state_d          = ST_GAP;
          gap_d            = '0;
        end else if (bus.seq_end) begin
          done_d[cur_q] = 1'b1;
          state_d       = ST_GAP;
          gap_d         = '0;
        end else if (wd_q == WD_LAST) begin
          aborted_d[cur_q] = 1'b1;
          tmo_d            = 1'b1;
          state_d          = ST_GAP;
          gap_d            = '0;
        end else if (enc_below) begin
          aborted_d[cur_q] = 1'b1;
          state_d          = ST_GAP;
          gap_d            = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh request beats the grant-time clear; mute flushes everything.
    if (bus.mute) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~clr) | bus.req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      cur_q     <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      select_q  <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      aborted_q <= '0;
      tmo_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        sel_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      select_q  <= select_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      tmo_q     <= tmo_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i] && !bus.mute) begin
          sel_q[i] <= bus.req_sel[i*SEL_W +: SEL_W];
        end
      end
    end
  end

  // Enable and busy decode straight from state so an async reset silences Audio immediately.
  assign bus.audio_enable = (state_q == ST_PLAY);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.audio_select = select_q;
  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.timeout_err  = tmo_q;

endmodule

// File: tb/tb_audio_request_arbiter.sv
// Directed self-checking bench for audio_request_arbiter (MAX_PLAY=100, GAP_CYCLES=2).
module tb_audio_request_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests  = 0;
  int unsigned failed = 0;

  audio_request_arbiter_if #(.NUM_REQ(4), .SEL_W(3)) bus ();

  audio_request_arbiter #(
    .NUM_REQ    (4),
    .SEL_W      (3),
    .GAP_CYCLES (2),
    .MAX_PLAY   (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req     = '0;
    bus.req_sel = '0;
    bus.mute    = 1'b0;
    bus.seq_end = 1'b0;
    tick();
    tick();
    chk("rst_enable", 32'(bus.audio_enable), 32'd0);
    chk("rst_select", 32'(bus.audio_select), 32'd0);
    chk("rst_busy",   32'(bus.busy),         32'd0);
    chk("rst_tmo",    32'(bus.timeout_err),  32'd0);
    rst = 1'b0;
    tick();

    // 1: single request, normal completion
    bus.req = 4'b0100; bus.req_sel = {3'd0, 3'd5, 3'd0, 3'd0};
    tick();
    bus.req = '0;
    chk("t1_lat1_enable", 32'(bus.audio_enable), 32'd0);
    tick();
    chk("t1_enable", 32'(bus.audio_enable), 32'd1);
    chk("t1_select", 32'(bus.audio_select), 32'd5);
    chk("t1_grant",  32'(bus.grant),        32'b0100);
    chk("t1_busy",   32'(bus.busy),         32'd1);
    tick();
    chk("t1_grant_pulse", 32'(bus.grant), 32'd0);
    repeat (17) tick();
    bus.seq_end = 1'b1;
    tick();
    bus.seq_end = 1'b0;
    chk("t1_done",     32'(bus.done),         32'b0100);
    chk("t1_gap_en",   32'(bus.audio_enable), 32'd0);
    chk("t1_gap_busy", 32'(bus.busy),         32'd1);
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    chk("t1_gap2_busy",  32'(bus.busy), 32'd1);
    chk("t1_gap2_en",    32'(bus.audio_enable), 32'd0);
    tick();
    chk("t1_idle_busy", 32'(bus.busy),   32'd0);
    chk("t1_idle_sel",  32'(bus.audio_select), 32'd5);

    // 2: simultaneous requests, priority order
    bus.req = 4'b1010; bus.req_sel = {3'd7, 3'd0, 3'd1, 3'd0};
    tick();
    bus.req = '0;
    tick();
    chk("t2_grant1",  32'(bus.grant),        32'b0010);
    chk("t2_select1", 32'(bus.audio_select), 32'd1);
    repeat (3) tick();
    bus.seq_end = 1'b1;
    tick();
    bus.seq_end = 1'b0;
    chk("t2_done1", 32'(bus.done), 32'b0010);
    tick();
    tick();
    chk("t2_idle_grant", 32'(bus.grant), 32'd0);
    tick();
    chk("t2_grant3",  32'(bus.grant),        32'b1000);
    chk("t2_select3", 32'(bus.audio_select), 32'd7);
    bus.seq_end = 1'b1;
    tick();
    bus.seq_end = 1'b0;
    chk("t2_done3", 32'(bus.done), 32'b1000);
    tick();
    tick();
    chk("t2_idle", 32'(bus.busy), 32'd0);

    // 3: preemption by higher priority
    bus.req = 4'b0100; bus.req_sel = {3'd0, 3'd2, 3'd0, 3'd0};
    tick();
    bus.req = '0;
    tick();
    chk("t3_grant2", 32'(bus.grant), 32'b0100);
    tick();
    bus.req = 4'b0001; bus.req_sel = {3'd0, 3'd0, 3'd0, 3'd4};
    tick();
    bus.req = '0;
    chk("t3_still_play", 32'(bus.audio_enable), 32'd1);
    tick();
    chk("t3_aborted", 32'(bus.aborted),      32'b0100);
    chk("t3_gap_en",  32'(bus.audio_enable), 32'd0);
    tick();
    chk("t3_abort_pulse", 32'(bus.aborted), 32'd0);
    tick();
    tick();
    chk("t3_grant0",  32'(bus.grant),        32'b0001);
    chk("t3_select0", 32'(bus.audio_select), 32'd4);
    bus.seq_end = 1'b1;
    tick();
    bus.seq_end = 1'b0;
    chk("t3_done0", 32'(bus.done), 32'b0001);
    tick();
    tick();
    tick();
    chk("t3_no_replay", 32'(bus.grant), 32'd0);
    chk("t3_idle",      32'(bus.busy),  32'd0);

    // 5: seq_end coincides with higher-priority request
    bus.req = 4'b0100; bus.req_sel = {3'd0, 3'd3, 3'd0, 3'd0};
    tick();
    bus.req = '0;
    tick();
    chk("t5_grant2", 32'(bus.grant), 32'b0100);
    tick();
    bus.req = 4'b0001; bus.req_sel = {3'd0, 3'd0, 3'd0, 3'd6};
    bus.seq_end = 1'b1;
    tick();
    bus.req = '0;
    bus.seq_end = 1'b0;
    chk("t5_done",    32'(bus.done),    32'b0100);
    chk("t5_no_abrt", 32'(bus.aborted), 32'd0);
    tick();
    tick();
    tick();
    chk("t5_grant0",  32'(bus.grant),        32'b0001);
    chk("t5_select0", 32'(bus.audio_select), 32'd6);
    bus.seq_end = 1'b1;
    tick();
    bus.seq_end = 1'b0;
    tick();
    tick();

    // 4: watchdog expiry
    bus.req = 4'b0010; bus.req_sel = {3'd0, 3'd0, 3'd6, 3'd0};
    tick();
    bus.req = '0;
    tick();
    chk("t4_grant1", 32'(bus.grant), 32'b0010);
    repeat (99) tick();
    chk("t4_last_play", 32'(bus.audio_enable), 32'd1);
    chk("t4_tmo_clear", 32'(bus.timeout_err),  32'd0);
    tick();
    chk("t4_aborted", 32'(bus.aborted),      32'b0010);
    chk("t4_tmo_set", 32'(bus.timeout_err),  32'd1);
    chk("t4_en_off",  32'(bus.audio_enable), 32'd0);
    tick();
    tick();
    chk("t4_idle",       32'(bus.busy),        32'd0);
    chk("t4_tmo_sticky", 32'(bus.timeout_err), 32'd1);

    // 6: mute flushes pending; reset mid-play
    bus.req = 4'b0100; bus.req_sel = {3'd0, 3'd1, 3'd0, 3'd0};
    tick();
    bus.req = '0;
    tick();
    chk("t6_grant2", 32'(bus.grant), 32'b0100);
    tick();
    bus.req = 4'b1000; bus.req_sel = {3'd3, 3'd0, 3'd0, 3'd0};
    tick();
    bus.req = '0;
    chk("t6_low_waits", 32'(bus.audio_enable), 32'd1);
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;
    chk("t6_aborted", 32'(bus.aborted),      32'b0100);
    chk("t6_en_off",  32'(bus.audio_enable), 32'd0);
    repeat (5) tick();
    chk("t6_flushed_en",   32'(bus.audio_enable), 32'd0);
    chk("t6_flushed_busy", 32'(bus.busy),         32'd0);

    bus.req = 4'b0001; bus.req_sel = {3'd0, 3'd0, 3'd0, 3'd2};
    tick();
    bus.req = '0;
    tick();
    chk("t6_grant0", 32'(bus.grant), 32'b0001);
    tick();
    chk("t6_pre_rst_en", 32'(bus.audio_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en",   32'(bus.audio_enable), 32'd0);
    chk("t6_rst_sel",  32'(bus.audio_select), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy),         32'd0);
    chk("t6_rst_tmo",  32'(bus.timeout_err),  32'd0);
    chk("t6_rst_pulses", 32'({bus.grant, bus.done, bus.aborted}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t6_post_rst", 32'({bus.audio_enable, bus.done, bus.aborted}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
